ahbl_slave_mem: RTL and testbench
=================================

AHBL_SLAVE_MEM -- requirements
Module: ahbl_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning HADDR width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning HWDATA/HRDATA width; legal values 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning number of DATA_WIDTH-bit words; power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning wait cycles inserted in every OKAY data phase; range 0..15.
REQ-005 SHALL have port HCLK, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port HRESETn, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port HSEL, input, 1, meaning slave select.
REQ-008 SHALL have port HADDR, input, ADDR_WIDTH, meaning byte address.
REQ-009 SHALL have ports HWRITE (input, 1), HSIZE (input, 3), HBURST (input, 3), HTRANS (input, 2), HPROT (input, 4) and HMASTLOCK (input, 1), with standard AHB-Lite meaning; HBURST, HPROT and HMASTLOCK are accepted and ignored.
REQ-010 SHALL have port HREADY, input, 1, meaning the bus-level ready from the interconnect.
REQ-011 SHALL have port HWDATA, input, DATA_WIDTH, meaning write data.
REQ-012 SHALL have port HRDATA, output, DATA_WIDTH, meaning read data.
REQ-013 SHALL have port HREADYOUT, output, 1, meaning the slave's ready.
REQ-014 SHALL have port HRESP, output, 1, meaning response: 0 = OKAY, 1 = ERROR.

Function
REQ-015 SHALL accept an address phase only on a rising edge with HSEL=1, HREADY=1 and HTRANS in {NONSEQ=2, SEQ=3}, registering HADDR, HWRITE and HSIZE.
REQ-016 SHALL give a zero-wait OKAY response (HREADYOUT=1, HRESP=0) in the data phase following IDLE (0), BUSY (1) or HSEL=0.
REQ-017 SHALL implement the states IDLE, WAIT, ERR1 and ERR2.
REQ-018 SHALL make these transitions: IDLE -> WAIT on a legal accepted transfer when WAIT_STATES>0; IDLE stays in IDLE when WAIT_STATES=0; WAIT -> IDLE when the counter reaches 0; IDLE -> ERR1 on an illegal accepted transfer; ERR1 -> ERR2 -> IDLE unconditionally.
REQ-019 SHALL treat a transfer as illegal when HADDR >= MEM_DEPTH*DATA_WIDTH/8, when 2**HSIZE > DATA_WIDTH/8, or when HADDR is not aligned to 2**HSIZE.
REQ-020 SHALL give an ERROR response over two cycles: ERR1 drives HREADYOUT=0 and HRESP=1; ERR2 drives HREADYOUT=1 and HRESP=1.
REQ-021 SHALL not modify memory on an erroring write.
REQ-022 SHALL not accept an address phase while in ERR1; a transfer presented with HREADY=1 in ERR2 SHALL be accepted normally.
REQ-023 SHALL, in the WAIT state, drive HREADYOUT=0 for exactly WAIT_STATES cycles, then HREADYOUT=1 with HRESP=0.
REQ-024 SHALL, on a write, update memory on the clock edge that ends the data phase (HREADYOUT=1), using HWDATA sampled at that edge.
REQ-025 SHALL, on a write, enable only the byte lanes selected by HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0] (little-endian).
REQ-026 SHALL, on a read, present the full memory word at index HADDR[log2(MEM_DEPTH*DATA_WIDTH/8)-1:log2(DATA_WIDTH/8)] on HRDATA in the cycle where HREADYOUT=1.
REQ-027 SHALL hold HRDATA at 0 outside read data phases.
REQ-028 SHALL, when a read follows a write to the same word back-to-back, return the newly written data (no stale read).
REQ-029 SHALL, when pipelined, accept the next address phase in the same cycle the previous data phase completes.
REQ-030 SHALL keep the wait counter log2(16) = 4 bits wide, and it SHALL not wrap.

Reset
REQ-031 SHALL, while HRESETn=0, force HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0 and the pending-transfer flag clear.
REQ-032 SHALL, on reset asserted mid data phase (WAIT, ERR1 or ERR2), abandon the transfer with no memory write.
REQ-033 SHALL not reset memory contents.

Verification
REQ-034 WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then NONSEQ read from 0x10 back-to-back -> read data phase returns 0xDEADBEEF with HREADYOUT=1 and no stalls.
REQ-035 WAIT_STATES=3: read from 0x20 -> HREADYOUT=0 for 3 cycles, then 1 with HRESP=0 and the correct HRDATA.
REQ-036 Byte write of 0xAA to 0x13 over word 0x11223344 -> subsequent read of 0x10 returns 0xAA223344.
REQ-037 Write to 0x400 (MEM_DEPTH=256, 32-bit data) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory is unchanged.
REQ-038 Misaligned halfword write to 0x01 -> two-cycle ERROR response; a following legal SEQ transfer completes OKAY.
REQ-039 HRESETn pulsed low during the 2nd wait cycle of a write -> outputs return to reset values immediately and the target word is unchanged.

Source files
------------

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite slave backed by a word-wide memory with optional fixed wait states
// and a two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no stall; completes a zero-wait data phase if one is pending
// ST_WAIT | legal data phase stalling; HREADYOUT rises when wait_cnt hits 0
// ST_ERR1 | first ERROR cycle: HREADYOUT=0, HRESP=1, no address accepted
// ST_ERR2 | second ERROR cycle: HREADYOUT=1, HRESP=1, next transfer accepted
module ahbl_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam int         BW        = $clog2(BYTES);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam int         AW_MEM    = IDX_W + BW;
    localparam logic [2:0] MAX_SIZE  = 3'(BW);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic                  pending, pending_nxt;
    logic [AW_MEM-1:0]     dp_addr;
    logic                  dp_write;
    logic [2:0]            dp_size;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  addr_ok, size_ok, align_ok, legal, accept;
    logic                  ready_int, resp_int, complete, mem_we;
    logic [BW-1:0]         dp_mask;
    logic [BYTES-1:0]      byte_en;
    logic [IDX_W-1:0]      dp_idx;
    logic                  unused_inputs;

    // Low address bits that must be zero for a transfer of the given size.
    function automatic logic [2:0] low_mask(input logic [2:0] size);
        case (size)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    always_comb begin
        addr_ok  = (HADDR >> AW_MEM) == '0;
        size_ok  = HSIZE <= MAX_SIZE;
        align_ok = (HADDR[2:0] & low_mask(HSIZE)) == 3'b000;
        legal    = addr_ok & size_ok & align_ok;
    end

    always_comb begin
        ready_int = 1'b1;
        resp_int  = 1'b0;
        case (state)
            ST_WAIT: ready_int = (wait_cnt == 4'd0);
            ST_ERR1: begin
                ready_int = 1'b0;
                resp_int  = 1'b1;
            end
            ST_ERR2: resp_int = 1'b1;
            default: ;
        endcase
    end

    // Gating on our own ready keeps ERR1 and stalled WAIT cycles from accepting.
    assign accept   = HSEL & HREADY & HTRANS[1] & ready_int;
    assign complete = pending & ready_int;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pending_nxt  = pending;
        case (state)
            ST_WAIT: begin
                if (wait_cnt != 4'd0) wait_cnt_nxt = wait_cnt - 4'd1;
                else                  state_nxt    = ST_IDLE;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        if (ready_int) pending_nxt = 1'b0;
        if (accept) begin
            pending_nxt = legal;
            if (!legal) begin
                state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = WAIT_LOAD;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            pending  <= 1'b0;
            dp_addr  <= '0;
            dp_write <= 1'b0;
            dp_size  <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            pending  <= pending_nxt;
            if (accept) begin
                dp_addr  <= HADDR[AW_MEM-1:0];
                dp_write <= HWRITE;
                dp_size  <= HSIZE;
            end
        end
    end

    assign dp_idx  = dp_addr[AW_MEM-1:BW];
    assign dp_mask = BW'(low_mask(dp_size));
    assign mem_we  = complete & dp_write;

    // A lane is enabled when it sits in the same naturally aligned block as dp_addr.
    always_comb begin
        byte_en = '0;
        for (int i = 0; i < BYTES; i++) begin
            byte_en[i] = ((BW'(i) ^ dp_addr[BW-1:0]) & ~dp_mask) == '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byte_en[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = (complete & ~dp_write) ? mem[dp_idx] : '0;
    assign HREADYOUT = ready_int;
    assign HRESP     = resp_int;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Directed bench for ahbl_slave_mem: one zero-wait instance and one three-wait instance,
// each a lone slave whose HREADY is its own HREADYOUT.
module tb_ahbl_slave_mem;

    logic        clk;
    logic        rst_n;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;

    int n_cmp;
    int n_bad;

    ahbl_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(hreadyout0), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahbl_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(hreadyout3), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size);
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
    endtask

    task automatic idle_bus();
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0;
        haddr = '0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b00;
        hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0; hwdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(hreadyout0), 32'd1);
        check("rst_resp0",  32'(hresp0),     32'd0);
        check("rst_rdata0", hrdata0,         32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait write then back-to-back read
        hsel0 = 1'b1;
        addr_ph(2'b10, 1'b1, 32'h10, 3'd2);
        @(negedge clk);
        check("wr_dp_ready", 32'(hreadyout0), 32'd1);
        hwdata = 32'hDEADBEEF;
        addr_ph(2'b10, 1'b0, 32'h10, 3'd2);
        @(negedge clk);
        check("raw_ready", 32'(hreadyout0), 32'd1);
        check("raw_resp",  32'(hresp0),     32'd0);
        check("raw_data",  hrdata0,         32'hDEADBEEF);
        idle_bus();
        @(negedge clk);
        check("idle_rdata", hrdata0, 32'h0);

        // word, byte and halfword writes with lane checks
        addr_ph(2'b10, 1'b1, 32'h00, 3'd2);
        @(negedge clk);
        hwdata = 32'h01020304;
        addr_ph(2'b11, 1'b1, 32'h10, 3'd2);
        @(negedge clk);
        hwdata = 32'h11223344;
        addr_ph(2'b11, 1'b1, 32'h13, 3'd0);
        @(negedge clk);
        hwdata = 32'hAA5A5A5A;
        addr_ph(2'b10, 1'b0, 32'h10, 3'd2);
        @(negedge clk);
        check("byte_lane", hrdata0, 32'hAA223344);
        addr_ph(2'b10, 1'b1, 32'h12, 3'd1);
        @(negedge clk);
        hwdata = 32'hC0DE1234;
        addr_ph(2'b10, 1'b0, 32'h10, 3'd2);
        @(negedge clk);
        check("half_lane", hrdata0, 32'hC0DE3344);
        addr_ph(2'b10, 1'b0, 32'h00, 3'd2);
        @(negedge clk);
        check("word0", hrdata0, 32'h01020304);
        idle_bus();
        @(negedge clk);

        // out-of-range write (would alias word 0), accept in ERR2
        addr_ph(2'b10, 1'b1, 32'h400, 3'd2);
        @(negedge clk);
        check("oor_err1_ready", 32'(hreadyout0), 32'd0);
        check("oor_err1_resp",  32'(hresp0),     32'd1);
        hwdata = 32'hFFFFFFFF;
        idle_bus();
        @(negedge clk);
        check("oor_err2_ready", 32'(hreadyout0), 32'd1);
        check("oor_err2_resp",  32'(hresp0),     32'd1);
        addr_ph(2'b10, 1'b0, 32'h00, 3'd2);
        @(negedge clk);
        check("oor_after_ready", 32'(hreadyout0), 32'd1);
        check("oor_after_resp",  32'(hresp0),     32'd0);
        check("oor_mem_kept",    hrdata0,         32'h01020304);

        // misaligned halfword write, then SEQ read issued during ERR2
        addr_ph(2'b10, 1'b1, 32'h01, 3'd1);
        @(negedge clk);
        check("mis_err1_ready", 32'(hreadyout0), 32'd0);
        check("mis_err1_resp",  32'(hresp0),     32'd1);
        hwdata = 32'hFFFFFFFF;
        idle_bus();
        @(negedge clk);
        check("mis_err2_ready", 32'(hreadyout0), 32'd1);
        check("mis_err2_resp",  32'(hresp0),     32'd1);
        addr_ph(2'b11, 1'b0, 32'h10, 3'd2);
        @(negedge clk);
        check("seq_ready", 32'(hreadyout0), 32'd1);
        check("seq_resp",  32'(hresp0),     32'd0);
        check("seq_data",  hrdata0,         32'hC0DE3344);
        addr_ph(2'b10, 1'b0, 32'h00, 3'd2);
        @(negedge clk);
        check("mis_mem_kept", hrdata0, 32'h01020304);

        // oversize transfer
        addr_ph(2'b10, 1'b0, 32'h08, 3'd3);
        @(negedge clk);
        check("size_err1_resp", 32'(hresp0), 32'd1);
        check("size_err_rdata", hrdata0,     32'h0);
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        check("size_done_resp", 32'(hresp0), 32'd0);

        // deselected write must be ignored
        hsel0 = 1'b0;
        addr_ph(2'b10, 1'b1, 32'h00, 3'd2);
        @(negedge clk);
        hwdata = 32'h55555555;
        hsel0 = 1'b1;
        addr_ph(2'b10, 1'b0, 32'h00, 3'd2);
        @(negedge clk);
        check("desel_mem_kept", hrdata0, 32'h01020304);
        idle_bus();
        hsel0 = 1'b0;
        @(negedge clk);

        // three wait states: write then pipelined read of 0x20
        hsel3 = 1'b1;
        addr_ph(2'b10, 1'b1, 32'h20, 3'd2);
        @(negedge clk);
        hwdata = 32'hCAFEF00D;
        idle_bus();
        for (int k = 0; k < 3; k++) begin
            check("ws_wr_stall", 32'(hreadyout3), 32'd0);
            @(negedge clk);
        end
        check("ws_wr_ready", 32'(hreadyout3), 32'd1);
        check("ws_wr_resp",  32'(hresp3),     32'd0);
        addr_ph(2'b10, 1'b0, 32'h20, 3'd2);
        @(negedge clk);
        idle_bus();
        for (int k = 0; k < 3; k++) begin
            check("ws_rd_stall", 32'(hreadyout3), 32'd0);
            @(negedge clk);
        end
        check("ws_rd_ready", 32'(hreadyout3), 32'd1);
        check("ws_rd_resp",  32'(hresp3),     32'd0);
        check("ws_rd_data",  hrdata3,         32'hCAFEF00D);
        @(negedge clk);

        // reset during second wait cycle of a write to 0x24
        addr_ph(2'b10, 1'b1, 32'h24, 3'd2);
        @(negedge clk);
        hwdata = 32'h12345678;
        idle_bus();
        repeat (3) @(negedge clk);
        check("pre_ready", 32'(hreadyout3), 32'd1);
        addr_ph(2'b10, 1'b1, 32'h24, 3'd2);
        @(negedge clk);
        check("rst_wait1", 32'(hreadyout3), 32'd0);
        hwdata = 32'h87654321;
        idle_bus();
        @(negedge clk);
        check("rst_wait2", 32'(hreadyout3), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(hreadyout3), 32'd1);
        check("mid_rst_resp",  32'(hresp3),     32'd0);
        check("mid_rst_rdata", hrdata3,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hwdata = '0;
        addr_ph(2'b10, 1'b0, 32'h24, 3'd2);
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        check("rst_ready_after", 32'(hreadyout3), 32'd1);
        check("rst_mem_kept",    hrdata3,         32'h12345678);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
